frac_clk_en_gen: RTL and testbench

FRAC_CLK_EN_GEN -- requirements
Module: frac_clk_en_gen

---
 rtl/frac_clk_en_gen_pkg.sv | 17 +
 rtl/frac_clk_en_gen_ch.sv | 59 +++++
 rtl/frac_clk_en_gen.sv | 45 ++++
 tb/tb_frac_clk_en_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/frac_clk_en_gen_pkg.sv
// Shared constants and types for the fractional clock-enable generator.
// Channel 0 drives the sample rate; channels 1 and 2 drive the timers.
package frac_clk_en_gen_pkg;

    localparam int NUM_CLK_EN_CH     = 3;
    localparam int CLK_EN_ACC_WIDTH  = 24;

    localparam int CLK_EN_SAMPLE     = 0;
    localparam int CLK_EN_TIMER1     = 1;
    localparam int CLK_EN_TIMER2     = 2;

    typedef struct packed {
        logic [CLK_EN_ACC_WIDTH-1:0] inc;
        logic [CLK_EN_ACC_WIDTH-1:0] mod;
    } clk_en_cfg_t;

endpackage

// File: rtl/frac_clk_en_gen_ch.sv
// One fractional clock-enable channel: phase accumulator modulo mod,
// stepping by inc, pulsing clk_en on every wrap.
module frac_clk_en_ch #(
    parameter int ACC_WIDTH   = 24,
    parameter int DEFAULT_MOD = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr,
    input  logic [ACC_WIDTH-1:0] wr_inc,
    input  logic [ACC_WIDTH-1:0] wr_mod,
    input  logic                 en,
    input  logic                 restart,
    output logic                 clk_en,
    output logic                 cfg_err
);

    localparam logic [ACC_WIDTH-1:0] MOD_RST = ACC_WIDTH'(DEFAULT_MOD);
    localparam logic [ACC_WIDTH-1:0] INC_RST = ACC_WIDTH'(1);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH-1:0] mod;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] wrap;
    logic                 hit;
    logic                 bad_cfg;

    // Full-width sum; acc < mod and inc <= mod keep the wrapped value in range.
    assign sum     = {1'b0, acc} + {1'b0, inc};
    assign hit     = sum >= {1'b0, mod};
    assign wrap    = sum[ACC_WIDTH-1:0] - mod;
    assign bad_cfg = (wr_mod == '0) || (wr_inc > wr_mod);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            inc     <= INC_RST;
            mod     <= MOD_RST;
            clk_en  <= 1'b0;
            cfg_err <= 1'b0;
        end else if (wr) begin
            acc     <= '0;
            inc     <= wr_inc;
            mod     <= wr_mod;
            clk_en  <= 1'b0;
            cfg_err <= bad_cfg;
        end else if (restart) begin
            acc    <= '0;
            clk_en <= 1'b0;
        end else if (en && !cfg_err) begin
            acc    <= hit ? wrap : sum[ACC_WIDTH-1:0];
            clk_en <= hit;
        end else begin
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/frac_clk_en_gen.sv
// Fractional clock-enable generator: NUM_CH independent channels,
// the top only steers configuration writes to the addressed channel.
module frac_clk_en_gen
    import frac_clk_en_gen_pkg::*;
#(
    parameter int NUM_CH      = NUM_CLK_EN_CH,
    parameter int ACC_WIDTH   = CLK_EN_ACC_WIDTH,
    parameter int DEFAULT_MOD = 256,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_wr,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    input  logic [ACC_WIDTH-1:0] cfg_mod,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [NUM_CH-1:0]    restart,
    output logic [NUM_CH-1:0]    clk_en,
    output logic [NUM_CH-1:0]    cfg_err
);

    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range channel numbers select nothing and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = cfg_wr && (cfg_ch == CH_W'(i));

        frac_clk_en_ch #(
            .ACC_WIDTH   (ACC_WIDTH),
            .DEFAULT_MOD (DEFAULT_MOD)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (wr_sel[i]),
            .wr_inc  (cfg_inc),
            .wr_mod  (cfg_mod),
            .en      (ch_en[i]),
            .restart (restart[i]),
            .clk_en  (clk_en[i]),
            .cfg_err (cfg_err[i])
        );
    end

endmodule

// File: tb/tb_frac_clk_en_gen.sv
// Directed bench for frac_clk_en_gen: pulse timing, enable gating,
// error configs, restart/cfg precedence and asynchronous reset.
module tb_frac_clk_en_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [23:0] cfg_inc;
    logic [23:0] cfg_mod;
    logic [2:0]  ch_en;
    logic [2:0]  restart;
    logic [2:0]  clk_en;
    logic [2:0]  cfg_err;

    int total = 0;
    int bad = 0;
    int n;
    int acc_n;
    int seen;

    frac_clk_en_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_inc (cfg_inc),
        .cfg_mod (cfg_mod),
        .ch_en   (ch_en),
        .restart (restart),
        .clk_en  (clk_en),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int ch, input int limit, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!clk_en[ch] && cnt < limit);
    endtask

    task automatic write(input logic [1:0] ch, input int inc, input int md);
        cfg_wr  = 1'b1;
        cfg_ch  = ch;
        cfg_inc = 24'(inc);
        cfg_mod = 24'(md);
        tick();
        cfg_wr  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        cfg_wr  = 1'b0;
        cfg_ch  = '0;
        cfg_inc = '0;
        cfg_mod = '0;
        ch_en   = '0;
        restart = '0;

        // reset state
        repeat (3) tick();
        chk("rst_clk_en", int'(clk_en), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);

        // defaults: first pulse after 256 cycles, period 256
        reset_n = 1'b1;
        ch_en   = 3'b001;
        wait_pulse(0, 300, n);
        chk("dflt_first", n, 256);
        chk("dflt_others", int'(clk_en[2:1]), 0);
        tick();
        chk("dflt_one_cycle", int'(clk_en[0]), 0);
        wait_pulse(0, 300, n);
        chk("dflt_period", n + 1, 256);

        // ch1 fractional timer: 1019, then 1018, 10th pulse at 10182
        ch_en = 3'b010;
        write(2'd1, 12500, 12727000);
        wait_pulse(1, 1100, n);
        chk("t1_first", n, 1019);
        wait_pulse(1, 1100, n);
        chk("t1_second", n, 1018);
        acc_n = 1019 + 1018;
        for (int k = 0; k < 8; k++) begin
            wait_pulse(1, 1100, n);
            acc_n += n;
        end
        chk("t1_ten_pulses", acc_n, 10182);

        // ch2 inc=1 mod=4 with a 10-cycle pause after 2 counts
        ch_en = 3'b100;
        write(2'd2, 1, 4);
        tick();
        tick();
        ch_en = 3'b000;
        seen  = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen |= int'(clk_en[2]);
        end
        chk("t2_paused", seen, 0);
        ch_en = 3'b100;
        wait_pulse(2, 10, n);
        chk("t2_resume", n, 2);

        // invalid inc>mod: error, no pulses
        ch_en = 3'b001;
        write(2'd0, 5, 4);
        chk("err_set", int'(cfg_err), 3'b001);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen |= int'(clk_en[0]);
        end
        chk("err_no_pulse", seen, 0);

        // inc==mod: pulse every cycle
        write(2'd0, 4, 4);
        chk("err_clear", int'(cfg_err[0]), 0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen += int'(clk_en[0]);
        end
        chk("full_rate", seen, 3);

        // mod==0 is invalid; inc==0 is valid but silent
        write(2'd0, 0, 0);
        chk("mod0_err", int'(cfg_err[0]), 1);
        write(2'd0, 0, 10);
        chk("inc0_ok", int'(cfg_err[0]), 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen |= int'(clk_en[0]);
        end
        chk("inc0_silent", seen, 0);

        // restart and write to ch1 together: write wins, period 3
        ch_en   = 3'b010;
        write(2'd1, 12500, 12727000);
        repeat (500) tick();
        restart = 3'b010;
        write(2'd1, 1, 3);
        restart = 3'b000;
        wait_pulse(1, 10, n);
        chk("rst_wr_first", n, 3);

        // write to channel 3 does nothing
        write(2'd3, 5, 4);
        chk("ch3_no_err", int'(cfg_err), 0);
        wait_pulse(1, 10, n);
        chk("ch3_period", n + 1, 3);

        // restart alone mid-count
        tick();
        restart = 3'b010;
        tick();
        restart = 3'b000;
        chk("restart_clr", int'(clk_en[1]), 0);
        wait_pulse(1, 10, n);
        chk("restart_period", n, 3);

        // asynchronous reset mid-count
        write(2'd0, 5, 4);
        ch_en = 3'b110;
        write(2'd2, 1, 4);
        wait_pulse(2, 10, n);
        chk("pre_arst_pulse", int'(clk_en[2]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_clk_en", int'(clk_en), 0);
        chk("arst_cfg_err", int'(cfg_err), 0);
        tick();
        reset_n = 1'b1;
        ch_en   = 3'b101;
        wait_pulse(2, 300, n);
        chk("arst_dflt_ch2", n, 256);
        chk("arst_dflt_ch0", int'(clk_en[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
